mem_fill_arbiter: RTL and testbench
===================================

MEM_FILL_ARBITER -- requirements
Module: mem_fill_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 15: WAIT-state cycles without mem_valid before the memory request is reissued.
REQ-002 Port CLK  input  1  sole clock; all state changes on rising edge.
REQ-003 Port RESET  input  1  synchronous, active-low reset.
REQ-004 Port i_req  input  1  instruction-cache block-fill request, level.
REQ-005 Port i_addr  input  32  instruction-cache miss address.
REQ-006 Port i_fill_data  output  256  block returned to instruction cache.
REQ-007 Port i_fill_valid  output  1  one-cycle strobe qualifying i_fill_data.
REQ-008 Port d_req  input  1  data-cache block-fill request, level.
REQ-009 Port d_addr  input  32  data-cache miss address.
REQ-010 Port d_fill_data  output  256  block returned to data cache.
REQ-011 Port d_fill_valid  output  1  one-cycle strobe qualifying d_fill_data.
REQ-012 Port mem_req  output  1  block-read request to main memory.
REQ-013 Port mem_addr  output  32  block-aligned read address; bits [4:0] always 0.
REQ-014 Port mem_ack  input  1  memory accepts mem_req this cycle.
REQ-015 Port mem_data  input  256  block from memory.
REQ-016 Port mem_valid  input  1  qualifies mem_data.
REQ-017 Port grant  output  2  one-hot owner: bit0 = I-side, bit1 = D-side; 00 when idle.
REQ-018 Port retry_cnt  output  4  count of timeout reissues, saturating at 15.

Function
REQ-019 States SHALL be IDLE, REQ, WAIT, RESP; all outputs are registered.
REQ-020 In IDLE with only one req high, that requester SHALL be granted at the next edge and the state SHALL move to REQ.
REQ-021 In IDLE with both reqs high, the requester not served last SHALL be granted (round-robin); after reset, last-served = D, so I wins the first tie.
REQ-022 At grant, the requester's address SHALL be latched with bits [4:0] cleared; later changes to i_addr/d_addr SHALL be ignored until RESP.
REQ-023 In REQ, mem_req SHALL be 1 and mem_addr SHALL hold the latched address; mem_ack=1 SHALL move the state to WAIT at that edge.
REQ-024 In WAIT, mem_req SHALL be 0; mem_valid=1 SHALL capture mem_data and move the state to RESP.
REQ-025 In WAIT, a cycle counter SHALL increment each cycle; when it reaches TIMEOUT with mem_valid=0, the state SHALL return to REQ, the counter SHALL clear, and retry_cnt SHALL increment (saturating).
REQ-026 If mem_valid and the timeout coincide, mem_valid SHALL win.
REQ-027 In RESP, exactly the granted side's fill_valid SHALL be 1 for one cycle with the captured block on its fill_data; the other side's fill_valid SHALL remain 0.
REQ-028 On leaving RESP, last-served SHALL update, grant SHALL clear to 00, and the state SHALL return to IDLE.
REQ-029 i_fill_data/d_fill_data SHALL hold their last delivered value between strobes.
REQ-030 A requester SHALL drop req in its fill_valid cycle; a req still high in the following IDLE cycle SHALL be treated as a new request.
REQ-031 mem_ack outside REQ and mem_valid outside WAIT SHALL be ignored.
REQ-032 Minimum latency: with req sampled at edge k, and mem_ack and mem_valid each high in the first cycle of their state, fill_valid SHALL be visible after edge k+3.
REQ-033 A req deasserted while granted SHALL NOT abort the transaction; the fill is still delivered.

Reset
REQ-034 When RESET=0 at a rising edge: state SHALL go to IDLE; grant, mem_req, mem_addr, both fill_valids, both fill_datas, retry_cnt and the WAIT counter SHALL go to 0; last-served SHALL go to D.
REQ-035 Reset mid-transaction SHALL abandon the transaction; a late mem_valid after reset SHALL produce no fill_valid.

Verification
REQ-036 Single I miss: i_req=1, i_addr=0x0000_1234; mem_ack and mem_valid immediate, mem_data=pattern A -> mem_addr=0x0000_1220, then i_fill_valid for one cycle with A, d_fill_valid=0.
REQ-037 Tie: i_req and d_req rise together after reset, held until served -> I served first, then D; repeat both -> order I, D, I, D.
REQ-038 Timeout: grant D, mem_ack=1, withhold mem_valid for 15 cycles -> mem_req reasserts with the same address and retry_cnt=1; then mem_valid -> d_fill_valid.
REQ-039 Coincidence: mem_valid arrives in exactly the timeout cycle -> RESP entered, no reissue, retry_cnt unchanged.
REQ-040 Reset in WAIT, then mem_valid pulse -> all outputs 0, no fill_valid, grant=00.
REQ-041 Address change: i_addr changes from 0x40 to 0x80 during REQ -> mem_addr stays 0x40.

Source files
------------

// File: rtl/mem_fill_arbiter.sv
// Two-requester block-fill arbiter. The instruction and data caches share one
// main-memory read port. Ties go round-robin, and a memory request that gets no
// data within TIMEOUT wait cycles is reissued.
module mem_fill_arbiter #(
  parameter int TIMEOUT = 15
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         i_req,
  input  logic [31:0]  i_addr,
  output logic [255:0] i_fill_data,
  output logic         i_fill_valid,
  input  logic         d_req,
  input  logic [31:0]  d_addr,
  output logic [255:0] d_fill_data,
  output logic         d_fill_valid,
  output logic         mem_req,
  output logic [31:0]  mem_addr,
  input  logic         mem_ack,
  input  logic [255:0] mem_data,
  input  logic         mem_valid,
  output logic [1:0]   grant,
  output logic [3:0]   retry_cnt
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  state_t         state_q, state_d;
  logic [1:0]     grant_q, grant_d;
  logic           mem_req_q, mem_req_d;
  logic [31:0]    mem_addr_q, mem_addr_d;
  logic [255:0]   blk_q, blk_d;
  logic [255:0]   i_fill_data_q, i_fill_data_d;
  logic [255:0]   d_fill_data_q, d_fill_data_d;
  logic           i_fill_valid_q, i_fill_valid_d;
  logic           d_fill_valid_q, d_fill_valid_d;
  logic [3:0]     retry_q, retry_d;
  logic [CW-1:0]  wait_cnt_q, wait_cnt_d;
  logic           last_d_q, last_d_d;   // 1 = data side served last

  // Next-state and registered-output logic for the arbitration FSM.
  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    mem_req_d      = mem_req_q;
    mem_addr_d     = mem_addr_q;
    blk_d          = blk_q;
    i_fill_data_d  = i_fill_data_q;
    d_fill_data_d  = d_fill_data_q;
    i_fill_valid_d = 1'b0;
    d_fill_valid_d = 1'b0;
    retry_d        = retry_q;
    wait_cnt_d     = wait_cnt_q;
    last_d_d       = last_d_q;
    case (state_q)
      S_IDLE: begin
        // On a tie, the I side wins only if D was served last.
        if (i_req && (!d_req || last_d_q)) begin
          grant_d    = 2'b01;
          mem_addr_d = {i_addr[31:5], 5'b0};
          mem_req_d  = 1'b1;
          state_d    = S_REQ;
        end else if (d_req) begin
          grant_d    = 2'b10;
          mem_addr_d = {d_addr[31:5], 5'b0};
          mem_req_d  = 1'b1;
          state_d    = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          mem_req_d  = 1'b0;
          wait_cnt_d = '0;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        // If data arrives in the timeout cycle, the data is taken and no reissue happens.
        if (mem_valid) begin
          blk_d   = mem_data;
          state_d = S_RESP;
        end else if (wait_cnt_q == CNT_LAST) begin
          wait_cnt_d = '0;
          mem_req_d  = 1'b1;
          if (retry_q != 4'hF) retry_d = retry_q + 4'd1;
          state_d    = S_REQ;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        if (grant_q[0]) begin
          i_fill_valid_d = 1'b1;
          i_fill_data_d  = blk_q;
        end else begin
          d_fill_valid_d = 1'b1;
          d_fill_data_d  = blk_q;
        end
        last_d_d = grant_q[1];
        grant_d  = 2'b00;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q        <= S_IDLE;
      grant_q        <= 2'b00;
      mem_req_q      <= 1'b0;
      mem_addr_q     <= '0;
      blk_q          <= '0;
      i_fill_data_q  <= '0;
      d_fill_data_q  <= '0;
      i_fill_valid_q <= 1'b0;
      d_fill_valid_q <= 1'b0;
      retry_q        <= '0;
      wait_cnt_q     <= '0;
      last_d_q       <= 1'b1;
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      mem_req_q      <= mem_req_d;
      mem_addr_q     <= mem_addr_d;
      blk_q          <= blk_d;
      i_fill_data_q  <= i_fill_data_d;
      d_fill_data_q  <= d_fill_data_d;
      i_fill_valid_q <= i_fill_valid_d;
      d_fill_valid_q <= d_fill_valid_d;
      retry_q        <= retry_d;
      wait_cnt_q     <= wait_cnt_d;
      last_d_q       <= last_d_d;
    end
  end

  assign grant        = grant_q;
  assign mem_req      = mem_req_q;
  assign mem_addr     = mem_addr_q;
  assign i_fill_data  = i_fill_data_q;
  assign d_fill_data  = d_fill_data_q;
  assign i_fill_valid = i_fill_valid_q;
  assign d_fill_valid = d_fill_valid_q;
  assign retry_cnt    = retry_q;

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Directed bench for mem_fill_arbiter. The expected fills are queued when memory
// data is driven. A negedge monitor pops and compares each fill strobe.
module tb_mem_fill_arbiter;

  logic         CLK = 1'b0;
  logic         RESET = 1'b0;
  logic         i_req = 1'b0, d_req = 1'b0;
  logic [31:0]  i_addr = '0, d_addr = '0;
  logic [255:0] i_fill_data, d_fill_data;
  logic         i_fill_valid, d_fill_valid;
  logic         mem_req, mem_ack = 1'b0, mem_valid = 1'b0;
  logic [31:0]  mem_addr;
  logic [255:0] mem_data = '0;
  logic [1:0]   grant;
  logic [3:0]   retry_cnt;

  typedef struct {
    logic [1:0]   side;
    logic [255:0] data;
  } fill_t;

  fill_t sb[$];
  int passed = 0;
  int total  = 0;

  mem_fill_arbiter #(.TIMEOUT(15)) dut (
    .CLK(CLK), .RESET(RESET),
    .i_req(i_req), .i_addr(i_addr), .i_fill_data(i_fill_data), .i_fill_valid(i_fill_valid),
    .d_req(d_req), .d_addr(d_addr), .d_fill_data(d_fill_data), .d_fill_valid(d_fill_valid),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_data(mem_data), .mem_valid(mem_valid),
    .grant(grant), .retry_cnt(retry_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Each fill strobe must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    if (i_fill_valid || d_fill_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_fill", {i_fill_valid, d_fill_valid}, 2'b00);
      end else begin
        fill_t e;
        e = sb.pop_front();
        check("fill_side", {d_fill_valid, i_fill_valid}, e.side);
        check("fill_data", e.side[0] ? i_fill_data : d_fill_data, e.data);
        $display("fill side=%b data=%0h", e.side, e.side[0] ? i_fill_data : d_fill_data);
      end
    end
  end

  task automatic wait_mem_req();
    int n = 0;
    while (!mem_req && n < 40) begin
      step();
      n++;
    end
    check("mem_req_wait", mem_req, 1'b1);
  endtask

  task automatic do_reset();
    RESET = 1'b0;
    step();
    step();
    RESET = 1'b1;
    check("rst_grant", grant, 2'b00);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_retry", retry_cnt, 4'd0);
    check("rst_fill_valid", {i_fill_valid, d_fill_valid}, 2'b00);
    check("rst_fill_data", {i_fill_data ^ d_fill_data} | i_fill_data, 256'h0);
  endtask

  // One transaction, starting from a request that is already pending. hold is
  // the number of WAIT cycles before mem_valid.
  task automatic run_txn(input logic [1:0] g, input logic [31:0] maddr,
                         input logic [255:0] data, input int hold,
                         input logic [3:0] exp_retry);
    fill_t e;
    wait_mem_req();
    check("grant", grant, g);
    check("mem_addr", mem_addr, maddr);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check("mem_req_low_in_wait", mem_req, 1'b0);
    repeat (hold) step();
    mem_valid = 1'b1;
    mem_data  = data;
    e.side = g;
    e.data = data;
    sb.push_back(e);
    step();
    mem_valid = 1'b0;
    check("no_reissue", mem_req, 1'b0);
    check("retry_cnt", retry_cnt, exp_retry);
    step();
    check("fill_strobe", {d_fill_valid, i_fill_valid}, g);
    check("grant_clear", grant, 2'b00);
    if (g[0]) i_req = 1'b0; else d_req = 1'b0;
    step();
    check("strobe_one_cycle", {d_fill_valid, i_fill_valid}, 2'b00);
    check("fill_hold", g[0] ? i_fill_data : d_fill_data, data);
    $display("txn grant=%b addr=%08h hold=%0d retry=%0d", g, maddr, hold, retry_cnt);
  endtask

  logic [255:0] pat_a, pat_b;

  initial begin
    pat_a = {8{32'hA5A5_0001}};
    pat_b = {8{32'h5A5A_0002}};
    do_reset();

    // Single I miss with immediate ack and data.
    i_req = 1'b1;
    i_addr = 32'h0000_1234;
    run_txn(2'b01, 32'h0000_1220, pat_a, 0, 4'd0);

    // Both requests rise together after reset. The order must be I, D, I, D.
    do_reset();
    i_req = 1'b1; i_addr = 32'h0000_2000;
    d_req = 1'b1; d_addr = 32'h0000_3010;
    run_txn(2'b01, 32'h0000_2000, pat_a ^ 256'h1, 0, 4'd0);
    run_txn(2'b10, 32'h0000_3000, pat_b ^ 256'h2, 0, 4'd0);
    i_req = 1'b1;
    d_req = 1'b1;
    run_txn(2'b01, 32'h0000_2000, pat_a ^ 256'h3, 0, 4'd0);
    run_txn(2'b10, 32'h0000_3000, pat_b ^ 256'h4, 0, 4'd0);

    // Timeout and reissue on the D side.
    d_req = 1'b1;
    d_addr = 32'h0000_ABCD;
    wait_mem_req();
    check("to_grant", grant, 2'b10);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    repeat (14) step();
    check("to_still_wait", mem_req, 1'b0);
    step();
    check("to_reissue", mem_req, 1'b1);
    check("to_addr", mem_addr, 32'h0000_ABC0);
    check("to_retry", retry_cnt, 4'd1);
    run_txn(2'b10, 32'h0000_ABC0, pat_b, 0, 4'd1);

    // mem_valid arrives in the timeout cycle, so there is no reissue.
    i_req = 1'b1;
    i_addr = 32'h0000_0500;
    run_txn(2'b01, 32'h0000_0500, pat_a ^ pat_b, 14, 4'd1);

    // Reset while in WAIT. A late mem_valid must be ignored.
    i_req = 1'b1;
    i_addr = 32'h0000_0700;
    wait_mem_req();
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    repeat (3) step();
    RESET = 1'b0;
    i_req = 1'b0;
    step();
    RESET = 1'b1;
    mem_valid = 1'b1;
    mem_data = pat_b;
    step();
    mem_valid = 1'b0;
    repeat (3) step();
    check("rw_fill_valid", {i_fill_valid, d_fill_valid}, 2'b00);
    check("rw_grant", grant, 2'b00);
    check("rw_mem_req", mem_req, 1'b0);
    check("rw_mem_addr", mem_addr, 32'h0);
    check("rw_retry", retry_cnt, 4'd0);
    check("rw_fill_data", i_fill_data | d_fill_data, 256'h0);

    // An address change during REQ is ignored.
    i_req = 1'b1;
    i_addr = 32'h0000_0040;
    wait_mem_req();
    i_addr = 32'h0000_0080;
    step();
    step();
    check("ac_mem_addr", mem_addr, 32'h0000_0040);
    run_txn(2'b01, 32'h0000_0040, pat_a, 0, 4'd0);

    repeat (3) step();
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
